// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// SPI_FAST_READ_EN selects fast read (0x0B plus one dummy byte).
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_IDLE,
        DONE
    } type_spi_seq_state_e;

    localparam logic [7:0] SPI_OPC_READ  = 8'h03;
    localparam logic [7:0] SPI_OPC_FREAD = 8'h0B;

`ifdef SPI_FAST_READ_EN
    localparam int         SPI_SEQ_HDR_LEN = 5;
    localparam logic [7:0] SPI_SEQ_OPC     = SPI_OPC_FREAD;
`else
    localparam int         SPI_SEQ_HDR_LEN = 4;
    localparam logic [7:0] SPI_SEQ_OPC     = SPI_OPC_READ;
`endif

endpackage

// File: rtl/spi_flash_rd_seq.sv
// SPI NOR read sequencer: pushes command header and fill bytes, streams payload.
// Build option SPI_FAST_READ_EN: fast-read opcode with one dummy byte.
module spi_flash_rd_seq
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic        done_o,
    output logic        tx_fifo_write_o,
    output logic [7:0]  tx_fifo_data_o,
    input  logic        tx_fifo_full_i,
    output logic        rx_fifo_read_o,
    input  logic [7:0]  rx_fifo_data_i,
    input  logic        rx_fifo_empty_i,
    input  logic        spi_busy_i,
    output logic        cs_hold_o
);

    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [8:0] HDR9 = 9'(SPI_SEQ_HDR_LEN);

    type_spi_seq_state_e state, state_nxt;

    logic [23:0]   addr;
    logic [8:0]    tx_rem;
    logic [8:0]    rx_rem;
    logic [8:0]    hdr_rem;
    logic [8:0]    len9;
    logic [OW-1:0] outstanding;
    logic [2:0]    tx_idx;
    logic          in_xfer;
    logic          accept;

    assign in_xfer     = state == XFER;
    assign req_ready_o = state == IDLE;
    assign cs_hold_o   = state != IDLE;
    assign done_o      = state == DONE;
    assign accept      = req_valid_i && req_ready_o;
    assign len9        = (req_len_i == 8'd0) ? 9'd256 : {1'b0, req_len_i};

    // Bound in-flight bytes so the RX FIFO cannot overflow under back-pressure.
    assign tx_fifo_write_o = in_xfer && tx_rem != 9'd0 && !tx_fifo_full_i
                             && outstanding < OW'(FIFO_DEPTH);

    assign rd_data_o  = rx_fifo_data_i;
    assign rd_valid_o = in_xfer && hdr_rem == 9'd0 && rx_rem != 9'd0
                        && !rx_fifo_empty_i;

    assign rx_fifo_read_o = (hdr_rem != 9'd0) ? (in_xfer && !rx_fifo_empty_i)
                                              : (rd_valid_o && rd_ready_i);

    // Only the first four header bytes carry content; the rest are zero fill.
    always_comb begin
        tx_fifo_data_o = 8'h00;
        if (in_xfer) begin
            case (tx_idx)
                3'd0:    tx_fifo_data_o = SPI_SEQ_OPC;
                3'd1:    tx_fifo_data_o = addr[23:16];
                3'd2:    tx_fifo_data_o = addr[15:8];
                3'd3:    tx_fifo_data_o = addr[7:0];
                default: tx_fifo_data_o = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            tx_rem      <= '0;
            rx_rem      <= '0;
            hdr_rem     <= '0;
            outstanding <= '0;
            tx_idx      <= '0;
        end else if (accept) begin
            addr        <= req_addr_i;
            tx_rem      <= HDR9 + len9;
            rx_rem      <= HDR9 + len9;
            hdr_rem     <= HDR9;
            outstanding <= '0;
            tx_idx      <= '0;
        end else begin
            if (tx_fifo_write_o) begin
                tx_rem <= tx_rem - 9'd1;
                if (tx_idx != 3'd7) tx_idx <= tx_idx + 3'd1;
            end
            if (rx_fifo_read_o) begin
                rx_rem <= rx_rem - 9'd1;
                if (hdr_rem != 9'd0) hdr_rem <= hdr_rem - 9'd1;
            end
            case ({tx_fifo_write_o, rx_fifo_read_o})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (req_valid_i)     state_nxt = XFER;
            XFER:      if (rx_rem == 9'd0)  state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (!spi_busy_i)     state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: queue-based SPI/FIFO model with random timing.
// Honours SPI_FAST_READ_EN for header length and opcode.
module tb_spi_flash_rd_seq;

`ifdef SPI_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [23:0] req_addr_i = '0;
    logic [7:0]  req_len_i = '0;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic        done_o;
    logic        tx_fifo_write_o;
    logic [7:0]  tx_fifo_data_o;
    logic        tx_fifo_full_i = 1'b0;
    logic        rx_fifo_read_o;
    logic [7:0]  rx_fifo_data_i = '0;
    logic        rx_fifo_empty_i = 1'b1;
    logic        spi_busy_i = 1'b0;
    logic        cs_hold_o;

    spi_flash_rd_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .done_o(done_o),
        .tx_fifo_write_o(tx_fifo_write_o), .tx_fifo_data_o(tx_fifo_data_o),
        .tx_fifo_full_i(tx_fifo_full_i), .rx_fifo_read_o(rx_fifo_read_o),
        .rx_fifo_data_i(rx_fifo_data_i), .rx_fifo_empty_i(rx_fifo_empty_i),
        .spi_busy_i(spi_busy_i), .cs_hold_o(cs_hold_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$], rxq[$], sent[$], rxlog[$], payload[$];
    int  sh_cnt = 0;
    int  pop_cnt = 0;
    int  done_cnt = 0;
    int  stall_pops = 0, bad_pops = 0, unstable = 0, push_full = 0, max_rxq = 0;
    bit  full_rand = 0, rdy_rand = 0, stall = 0, busy_force = 0;
    logic       c_push, c_pop, c_rdv, c_rdy, c_done, c_full;
    logic [7:0] c_data, c_rdd, prev_data, nb;
    bit         prev_hold = 0;

    // SPI engine + FIFOs: a pushed byte is shifted out 1..3 cycles later and
    // returns one random RX byte; the consumer is driven from here too.
    always begin
        @(posedge clk);
        c_push = tx_fifo_write_o; c_data = tx_fifo_data_o;
        c_pop  = rx_fifo_read_o;  c_rdv  = rd_valid_o;
        c_rdd  = rd_data_o;       c_rdy  = rd_ready_i;
        c_done = done_o;          c_full = tx_fifo_full_i;
        @(negedge clk);
        if (!rst_n) begin
            txq.delete(); rxq.delete(); sh_cnt = 0; prev_hold = 0;
        end else begin
            if (c_done) done_cnt++;
            if (c_push && c_full) push_full++;
            if (c_push) begin txq.push_back(c_data); sent.push_back(c_data); end
            if (prev_hold && !(c_rdv && c_rdd == prev_data)) unstable++;
            prev_hold = c_rdv && !c_rdy;
            prev_data = c_rdd;
            if (c_rdv && c_rdy && !c_pop) bad_pops++;
            if (c_pop) begin
                if (rxq.size() == 0) bad_pops++;
                else begin
                    if (pop_cnt >= HDR) begin
                        if (!c_rdy) stall_pops++;
                        payload.push_back(c_rdd);
                    end else if (c_rdv) bad_pops++;
                    void'(rxq.pop_front());
                    pop_cnt++;
                end
            end
            if (sh_cnt > 0) begin
                sh_cnt--;
                if (sh_cnt == 0) begin
                    nb = 8'($urandom);
                    rxq.push_back(nb); rxlog.push_back(nb);
                end
            end
            if (sh_cnt == 0 && txq.size() > 0) begin
                void'(txq.pop_front());
                sh_cnt = $urandom_range(1, 3);
            end
            if (rxq.size() > max_rxq) max_rxq = rxq.size();
        end
        rx_fifo_empty_i = rxq.size() == 0;
        rx_fifo_data_i  = (rxq.size() == 0) ? 8'h00 : rxq[0];
        tx_fifo_full_i  = txq.size() >= 4 || (full_rand && $urandom_range(0, 3) == 0);
        spi_busy_i      = txq.size() > 0 || sh_cnt > 0 || busy_force;
        rd_ready_i      = stall ? 1'b0 : (rdy_rand ? 1'($urandom) : 1'b1);
    end

    function automatic int tx_errs(logic [23:0] a, int n9);
        logic [7:0] e[$];
        int n;
        e = {OPC, a[23:16], a[15:8], a[7:0]};
        if (HDR == 5) e.push_back(8'h00);
        repeat (n9) e.push_back(8'h00);
        n = (sent.size() == e.size()) ? 0 : 1;
        for (int i = 0; i < sent.size() && i < e.size(); i++)
            if (sent[i] !== e[i]) n++;
        return n;
    endfunction

    function automatic int rx_errs(int n9);
        int n;
        n = (payload.size() == n9 && rxlog.size() == HDR + n9) ? 0 : 1;
        for (int i = 0; i < payload.size() && HDR + i < rxlog.size(); i++)
            if (payload[i] !== rxlog[HDR + i]) n++;
        return n;
    endfunction

    function automatic int viol();
        return stall_pops + bad_pops + unstable + push_full + int'(max_rxq > DEPTH);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_req(input logic [23:0] a, input logic [7:0] l);
        sent.delete(); rxlog.delete(); payload.delete();
        pop_cnt = 0; done_cnt = 0;
        req_addr_i = a; req_len_i = l; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < lim) begin tick(); n++; end
        ok = done_cnt != 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        tick();
        checks += 7;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready_o); end
        if (cs_hold_o !== 1'b0) begin errors++; $display("FAIL rst_cs_hold got %b exp 0", cs_hold_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done_o); end
        if (tx_fifo_write_o !== 1'b0) begin errors++; $display("FAIL rst_tx_write got %b exp 0", tx_fifo_write_o); end
        if (tx_fifo_data_o !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_fifo_data_o); end
        if (rx_fifo_read_o !== 1'b0) begin errors++; $display("FAIL rst_rx_read got %b exp 0", rx_fifo_read_o); end
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid_o); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready_o !== 1'b1 || cs_hold_o !== 1'b0)
            begin errors++; $display("FAIL idle_after_rst got %b%b exp 10", req_ready_o, cs_hold_o); end
    endtask

    task automatic test_basic();
        bit ok;
        full_rand = 0; rdy_rand = 0;
        start_req(24'h123456, 8'd4);
        checks += 3;
        if (req_ready_o !== 1'b0 || cs_hold_o !== 1'b1)
            begin errors++; $display("FAIL accept got %b%b exp 01", req_ready_o, cs_hold_o); end
        if (tx_fifo_write_o !== 1'b1)
            begin errors++; $display("FAIL first_push got %b exp 1", tx_fifo_write_o); end
        if (tx_fifo_data_o !== OPC)
            begin errors++; $display("FAIL first_byte got %h exp %h", tx_fifo_data_o, OPC); end
        req_addr_i = 24'hABCDEF; req_valid_i = 1'b1;
        repeat (4) tick();
        req_valid_i = 1'b0;
        wait_done(2000, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL basic_done got timeout exp pulse"); end
        if (tx_errs(24'h123456, 4) != 0) begin errors++; $display("FAIL basic_tx got %0d bad exp 0", tx_errs(24'h123456, 4)); end
        if (rx_errs(4) != 0) begin errors++; $display("FAIL basic_rx got %0d bad exp 0", rx_errs(4)); end
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
        if (viol() != 0) begin errors++; $display("FAIL basic_proto got %0d exp 0", viol()); end
    endtask

    task automatic test_random();
        bit ok;
        logic [23:0] a;
        int l;
        for (int k = 0; k < 4; k++) begin
            a = 24'($urandom); l = $urandom_range(1, 40);
            full_rand = 1'($urandom); rdy_rand = 1'($urandom);
            start_req(a, 8'(l));
            wait_done(5000, ok);
            checks += 4;
            if (!ok) begin errors++; $display("FAIL rand_done got timeout exp pulse"); end
            if (tx_errs(a, l) != 0) begin errors++; $display("FAIL rand_tx got %0d bad exp 0", tx_errs(a, l)); end
            if (rx_errs(l) != 0) begin errors++; $display("FAIL rand_rx got %0d bad exp 0", rx_errs(l)); end
            if (done_cnt != 1 || viol() != 0)
                begin errors++; $display("FAIL rand_proto got %0d/%0d exp 1/0", done_cnt, viol()); end
        end
    endtask

    task automatic test_len_wrap();
        bit ok;
        logic [23:0] a = 24'($urandom);
        full_rand = 1; rdy_rand = 1;
        start_req(a, 8'd0);
        wait_done(20000, ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL wrap_done got timeout exp pulse"); end
        if (sent.size() != HDR + 256) begin errors++; $display("FAIL wrap_push_cnt got %0d exp %0d", sent.size(), HDR + 256); end
        if (rx_errs(256) != 0) begin errors++; $display("FAIL wrap_rx got %0d bad exp 0 (n=%0d)", rx_errs(256), payload.size()); end
        if (tx_errs(a, 256) != 0) begin errors++; $display("FAIL wrap_tx got %0d bad exp 0", tx_errs(a, 256)); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        int n = 0, p0;
        logic [23:0] a = 24'($urandom);
        full_rand = 0; rdy_rand = 1;
        start_req(a, 8'd64);
        while (payload.size() < 10 && n < 2000) begin tick(); n++; end
        stall = 1;
        repeat (2) tick();
        p0 = payload.size();
        repeat (100) tick();
        checks += 4;
        if (payload.size() != p0) begin errors++; $display("FAIL bp_consumed got %0d exp %0d", payload.size(), p0); end
        if (rxq.size() != DEPTH) begin errors++; $display("FAIL bp_rx_level got %0d exp %0d", rxq.size(), DEPTH); end
        if (sent.size() != pop_cnt + DEPTH) begin errors++; $display("FAIL bp_in_flight got %0d exp %0d", sent.size() - pop_cnt, DEPTH); end
        if (tx_fifo_write_o !== 1'b0) begin errors++; $display("FAIL bp_push_stop got %b exp 0", tx_fifo_write_o); end
        stall = 0;
        wait_done(5000, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL bp_done got timeout exp pulse"); end
        if (rx_errs(64) != 0) begin errors++; $display("FAIL bp_rx got %0d bad exp 0", rx_errs(64)); end
        if (viol() != 0) begin errors++; $display("FAIL bp_proto got %0d exp 0", viol()); end
    endtask

    task automatic test_busy_tail();
        int n = 0, bad = 0;
        full_rand = 0; rdy_rand = 0; busy_force = 1;
        start_req(24'h00A5A5, 8'd6);
        while (payload.size() < 6 && n < 2000) begin tick(); n++; end
        repeat (20) begin
            tick();
            if (cs_hold_o !== 1'b1 || done_o !== 1'b0) bad++;
        end
        checks += 3;
        if (bad != 0 || done_cnt != 0) begin errors++; $display("FAIL tail_hold got %0d bad exp 0", bad + done_cnt); end
        busy_force = 0;
        if (done_o !== 1'b0) begin errors++; $display("FAIL tail_early got %b exp 0", done_o); end
        tick();
        if (done_o !== 1'b1) begin errors++; $display("FAIL tail_done got %b exp 1", done_o); end
        repeat (3) tick();
        checks += 2;
        if (rx_errs(6) != 0) begin errors++; $display("FAIL tail_rx got %0d bad exp 0", rx_errs(6)); end
        if (done_cnt != 1 || cs_hold_o !== 1'b0)
            begin errors++; $display("FAIL tail_end got %0d/%b exp 1/0", done_cnt, cs_hold_o); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [23:0] a = 24'($urandom);
        full_rand = 0; rdy_rand = 1;
        start_req(24'h0F0F0F, 8'd50);
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (cs_hold_o !== 1'b0) begin errors++; $display("FAIL mrst_cs_hold got %b exp 0", cs_hold_o); end
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b exp 1", req_ready_o); end
        if (tx_fifo_write_o !== 1'b0 || tx_fifo_data_o !== 8'h00)
            begin errors++; $display("FAIL mrst_tx got %b/%h exp 0/00", tx_fifo_write_o, tx_fifo_data_o); end
        if (rx_fifo_read_o !== 1'b0 || rd_valid_o !== 1'b0)
            begin errors++; $display("FAIL mrst_rx got %b%b exp 00", rx_fifo_read_o, rd_valid_o); end
        if (done_o !== 1'b0) begin errors++; $display("FAIL mrst_done got %b exp 0", done_o); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        start_req(a, 8'd12);
        wait_done(5000, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL mrst_redo_done got timeout exp pulse"); end
        if (tx_errs(a, 12) != 0) begin errors++; $display("FAIL mrst_redo_tx got %0d bad exp 0", tx_errs(a, 12)); end
        if (rx_errs(12) != 0) begin errors++; $display("FAIL mrst_redo_rx got %0d bad exp 0", rx_errs(12)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_len_wrap();
        test_back_pressure();
        test_busy_tail();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
